// File: rtl/keypad_pkg.sv
// Shared widths, frame-result encoding and debounce states for the keypad scanner.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    // Frame result: {valid, code}; valid=0 means no single key seen this frame.
    typedef logic [KEY_W:0] result_t;
    localparam result_t KEY_NONE = '0;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } db_state_t;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: accepts a key after DEBOUNCE matching frames, releases after DEBOUNCE non-matching frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_strobe,
    input  result_t          i_frame_result,
    output logic [KEY_W-1:0] o_key_code,
    output logic             o_key_valid,
    output logic             o_key_held
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    db_state_t        r_state;
    db_state_t        w_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [CW-1:0]    w_cnt_inc;
    logic [KEY_W-1:0] r_cand;
    logic [KEY_W-1:0] w_cand_next;
    logic [KEY_W-1:0] r_code;
    logic             r_valid;
    logic             w_accept;
    logic             w_match;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_match   = (i_frame_result == {1'b1, r_cand});

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_cand_next = r_cand;
        w_accept    = 1'b0;
        if (i_frame_strobe) begin
            unique case (r_state)
                IDLE: begin
                    if (i_frame_result[KEY_W]) begin
                        w_cand_next = i_frame_result[KEY_W-1:0];
                        w_cnt_next  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            w_next   = HELD;
                            w_accept = 1'b1;
                        end else begin
                            w_next = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (w_match) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CW'(DEBOUNCE)) begin
                            w_next   = HELD;
                            w_accept = 1'b1;
                        end
                    end else begin
                        w_next = IDLE;
                    end
                end
                HELD: begin
                    if (!w_match) begin
                        w_cnt_next = CW'(1);
                        w_next     = (DEBOUNCE == 1) ? IDLE : REL_CHK;
                    end
                end
                REL_CHK: begin
                    if (w_match) begin
                        w_next = HELD;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CW'(DEBOUNCE)) w_next = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt   <= '0;
            r_cand  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
            r_valid <= w_accept;
            if (w_accept) r_code <= w_cand_next;
        end
    end

    // Bouncing back from REL_CHK to HELD keeps key_held high without a new pulse.
    always_comb begin
        o_key_code  = r_code;
        o_key_valid = r_valid;
        o_key_held  = (r_state == HELD) || (r_state == REL_CHK);
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, row synchronisation, per-frame single-key detection.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_sel,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [ROWS-1:0]  r_sync1;
    logic [ROWS-1:0]  r_sync2;
    logic [DW-1:0]    r_dwell;
    logic [1:0]       r_col;
    logic [1:0]       r_acc_cnt;
    logic [KEY_W-1:0] r_acc_code;

    logic             w_sample;
    logic             w_frame_strobe;
    result_t          w_frame_result;
    logic [2:0]       w_col_hits;
    logic [KEY_W-1:0] w_col_code;
    logic [2:0]       w_total;
    logic [1:0]       w_sum_cnt;
    logic [KEY_W-1:0] w_sum_code;

    assign w_sample       = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_frame_strobe = w_sample && (r_col == 2'd3);
    assign col_sel        = ~(4'b0001 << r_col);

    // Hit count saturates at 2: anything beyond one key in a frame is rejected alike.
    always_comb begin
        w_col_hits = '0;
        w_col_code = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (!r_sync2[r]) begin
                w_col_hits = w_col_hits + 3'd1;
                w_col_code = {r_col, 2'(r)};
            end
        end
        w_total        = {1'b0, r_acc_cnt} + w_col_hits;
        w_sum_cnt      = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
        w_sum_code     = (w_col_hits != 3'd0) ? w_col_code : r_acc_code;
        w_frame_result = (w_sum_cnt == 2'd1) ? {1'b1, w_sum_code} : KEY_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_dwell    <= '0;
            r_col      <= '0;
            r_acc_cnt  <= '0;
            r_acc_code <= '0;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
            if (w_sample) begin
                r_dwell <= '0;
                r_col   <= r_col + 2'd1;
                if (r_col == 2'd3) begin
                    r_acc_cnt  <= '0;
                    r_acc_code <= '0;
                end else begin
                    r_acc_cnt  <= w_sum_cnt;
                    r_acc_code <= w_sum_code;
                end
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_frame_strobe (w_frame_strobe),
        .i_frame_result (w_frame_result),
        .o_key_code     (key_code),
        .o_key_valid    (key_valid),
        .o_key_held     (key_held)
    );

endmodule
